// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed hex display scanner. It holds a 32-bit value, steps through the
// nibbles one slot at a time, and applies dead time plus leading-zero blanking.
module display_scan_ctrl #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int LZ_BLANK     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_in,
    input  logic        load,
    output logic        load_ack,
    input  logic        hold,
    output logic [7:0]  an_n,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        frame_start
);

    localparam int              CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0]   BLANK_CW = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt, next_cnt;
    logic [2:0]    idx, next_idx;
    logic [31:0]   disp_reg, next_disp;
    logic [31:0]   shadow;
    logic          pending;

    logic          tick;
    logic          boundary;
    logic          transfer;
    logic          lz_zero;
    logic          blank_d;
    logic [7:0]    an_n_d;
    logic [3:0]    digit_d;

    // Load handshake: load is a one-cycle request that may repeat before it is honoured
    // (the last data wins); load_ack pulses once, on the frame where that data first shows.
    always_comb begin
        tick      = (cnt == CNT_MAX);
        boundary  = tick && (idx == 3'd7);
        transfer  = boundary && (pending || load) && !hold;
        next_cnt  = tick ? '0 : cnt + 1'b1;
        next_idx  = tick ? idx + 3'd1 : idx;
        next_disp = disp_reg;
        if (transfer) begin
            next_disp = load ? data_in : shadow;
        end
    end

    // Outputs are computed from the post-edge slot so they line up with idx and cnt.
    always_comb begin
        lz_zero = ((next_disp >> {next_idx, 2'b00}) == 32'd0);
        blank_d = (next_cnt < BLANK_CW) ||
                  ((LZ_BLANK != 0) && (next_idx != 3'd0) && lz_zero);
        an_n_d  = blank_d ? 8'hFF : ~(8'b1 << next_idx);
        digit_d = next_disp[{next_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= 3'd0;
            disp_reg <= 32'd0;
            shadow   <= 32'd0;
            pending  <= 1'b0;
        end else begin
            cnt      <= next_cnt;
            idx      <= next_idx;
            disp_reg <= next_disp;
            if (load) begin
                shadow <= data_in;
            end
            if (transfer) begin
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n        <= 8'hFF;
            digit       <= 4'd0;
            blank       <= 1'b1;
            load_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            an_n        <= an_n_d;
            digit       <= digit_d;
            blank       <= blank_d;
            load_ack    <= transfer;
            frame_start <= boundary;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl with a short prescaler. Expected frames are queued by the
// stimulus and checked cycle by cycle by a monitor that syncs on frame_start.
module tb_display_scan_ctrl;

    localparam int P = 4;
    localparam int B = 1;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_in;
    logic        load;
    logic        hold;
    logic        load_ack;
    logic [7:0]  an_n;
    logic [3:0]  digit;
    logic        blank;
    logic        frame_start;

    logic        lz0_load_ack;
    logic [7:0]  lz0_an_n;
    logic [3:0]  lz0_digit;
    logic        lz0_blank;
    logic        lz0_frame_start;

    int checks = 0;
    int errors = 0;

    // Entry: {display value[31:0], lit-digit mask[7:0], ack expected at frame start}
    logic [40:0] exp_q[$];

    display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B), .LZ_BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .load_ack(load_ack),
        .hold(hold), .an_n(an_n), .digit(digit), .blank(blank), .frame_start(frame_start)
    );

    display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B), .LZ_BLANK(0)) dut_lz0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .load_ack(lz0_load_ack),
        .hold(hold), .an_n(lz0_an_n), .digit(lz0_digit), .blank(lz0_blank),
        .frame_start(lz0_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [40:0] mk(input logic [31:0] val, input logic [7:0] mask,
                                       input logic ack);
        return {val, mask, ack};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v);
        data_in = v;
        load    = 1'b1;
        cycle();
        load    = 1'b0;
    endtask

    task automatic wait_frame();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cycle();
            if (frame_start) got = 1'b1;
        end
        chk("frame_start_seen", {63'd0, got}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {an_n, digit, blank, load_ack, frame_start}, {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0});
    endtask

    task automatic check_first_slot(input string name);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk(name, {an_n, digit, blank}, {8'hFE, 4'h0, 1'b0});
        end
    endtask

    // Monitor: on each frame_start with a queued entry, check all 32 cycles of the frame.
    initial begin : monitor
        logic [40:0] cur;
        logic [31:0] val;
        logic [7:0]  mask;
        logic [7:0]  e_an;
        logic [3:0]  e_dig;
        logic        en;
        int          off;
        int          slot;
        bit          act;
        act = 0;
        off = 0;
        cur = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                act = 0;
            end else begin
                if (!act && frame_start && exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    act = 1;
                    off = 0;
                end
                if (act) begin
                    val   = cur[40:9];
                    mask  = cur[8:1];
                    slot  = off / P;
                    en    = mask[slot] && ((off % P) >= B);
                    e_an  = en ? ~(8'b1 << slot) : 8'hFF;
                    e_dig = val[4*slot +: 4];
                    chk($sformatf("scan val=%h off=%0d", val, off),
                        {an_n, digit, blank, load_ack, frame_start},
                        {e_an, e_dig, !en, (off == 0) ? cur[0] : 1'b0, off == 0});
                    off++;
                    if (off == 8 * P) act = 0;
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        hold    = 1'b0;
        data_in = 32'd0;
        exp_q.push_back(mk(32'd0, 8'h01, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        check_first_slot("first_slot_after_reset");

        wait_frame();  // frame 1
        exp_q.push_back(mk(32'd0, 8'h01, 1'b0));

        wait_frame();  // frame 2: load mid-frame, visible from frame 3
        exp_q.push_back(mk(32'h1234ABCD, 8'hFF, 1'b1));
        repeat (10) cycle();
        do_load(32'h1234ABCD);

        wait_frame();  // frame 3
        exp_q.push_back(mk(32'h00000F00, 8'h07, 1'b1));
        repeat (5) cycle();
        do_load(32'h00000F00);

        wait_frame();  // frame 4: hold + deferred load; LZ_BLANK=0 instance lights all digits
        exp_q.push_back(mk(32'h00000F00, 8'h07, 1'b0));
        hold    = 1'b1;
        data_in = 32'hDEADBEEF;
        load    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] e;
            cycle();
            load = 1'b0;
            e = ~(8'b1 << i);
            chk($sformatf("lz0_an_n slot %0d", i), {56'd0, lz0_an_n}, {56'd0, e});
            if (i < 7) repeat (P - 1) cycle();
        end

        wait_frame();  // frame 5
        exp_q.push_back(mk(32'h00000F00, 8'h07, 1'b0));
        wait_frame();  // frame 6
        exp_q.push_back(mk(32'h00000F00, 8'h07, 1'b0));
        wait_frame();  // frame 7: hold drops, transfer at next boundary
        exp_q.push_back(mk(32'hDEADBEEF, 8'hFF, 1'b1));
        repeat (7) cycle();
        hold = 1'b0;

        wait_frame();  // frame 8: two loads, then a third on the boundary cycle
        exp_q.push_back(mk(32'h33333333, 8'hFF, 1'b1));
        repeat (5) cycle();
        do_load(32'h11111111);
        repeat (10) cycle();
        do_load(32'h22222222);
        repeat (14) cycle();
        data_in = 32'h33333333;
        load    = 1'b1;
        cycle();  // frame 9 starts here
        load    = 1'b0;
        chk("boundary_load_frame_start", {63'd0, frame_start}, 64'd1);
        exp_q.push_back(mk(32'h33333333, 8'hFF, 1'b0));

        wait_frame();  // frame 10: queue a held load, then reset mid-slot at idx 5
        hold = 1'b1;
        do_load(32'h55555555);
        repeat (21) cycle();
        chk("pre_reset_an_n", {56'd0, an_n}, {56'd0, 8'hDF});
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        chk("lz0_async_reset", {lz0_an_n, lz0_digit, lz0_blank, lz0_load_ack, lz0_frame_start},
            {8'hFF, 4'h0, 1'b1, 1'b0, 1'b0});
        hold = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(32'd0, 8'h01, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        check_first_slot("first_slot_after_mid_reset");

        wait_frame();  // pending load discarded by reset: still shows 0 with no ack
        exp_q.push_back(mk(32'd0, 8'h01, 1'b0));
        wait_frame();
        repeat (8 * P) cycle();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
